ysyx_22041211_ifu: RTL
======================

# ysyx_22041211_ifu

Instruction fetch unit sitting directly downstream of the PC counter in the NPC core. Takes the current PC, issues a single-outstanding read request to instruction memory over a valid/ready interface, and holds the returned instruction for decode until it is accepted. Produces `pc_plus_4` for the counter and a one-cycle PC write-enable, so the core becomes multi-cycle and tolerates memory latency and decode backpressure.

## Interface
- `ADDR_LEN`, 32, PC/address width
- `DATA_LEN`, 32, instruction width
- `RESET_PC`, 32'h8000_0000, reset value of the internal PC latch

- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset. Synchronous and active-high.
- `pc_i`  in  ADDR_LEN  current PC from counter
- `branch_flush_i`  in  1  one-cycle redirect pulse; the counter loads the target on the same edge
- `imem_req_valid_o`  out  1  fetch request valid
- `imem_req_ready_i`  in  1  memory accepts request
- `imem_addr_o`  out  ADDR_LEN  fetch address
- `imem_rsp_valid_i`  in  1  read data valid
- `imem_rsp_data_i`  in  DATA_LEN  read data
- `inst_valid_o`  out  1  instruction valid to decode
- `inst_ready_i`  in  1  decode accepts instruction
- `inst_o`  out  DATA_LEN  held instruction
- `inst_pc_o`  out  ADDR_LEN  PC of held instruction
- `pc_plus_4_o`  out  ADDR_LEN  `inst_pc_o + 4`, to counter
- `pc_we_o`  out  1  counter advance strobe

## Operation
- FSM states:
  - IDLE:
    - `imem_req_valid_o = ~branch_flush_i`.
    - `imem_addr_o = pc_i`.
    - On `req_valid & req_ready`: latch `pc_q <= pc_i` and go to WAIT.
  - WAIT: waiting for the response.
    - On `rsp_valid`:
      - If `discard_q`, or `branch_flush_i` this cycle: drop the data, clear `discard_q`, go to IDLE.
      - Otherwise: `inst_q <= rsp_data` and go to HOLD.
    - `branch_flush_i` without `rsp_valid`: set `discard_q` and stay in WAIT.
  - HOLD:
    - `inst_valid_o = ~branch_flush_i`.
    - On `inst_ready_i & ~branch_flush_i`: `pc_we_o = 1`, go to IDLE.
    - On `branch_flush_i`: go to IDLE and drop the instruction; `pc_we_o` stays 0.
- `imem_rsp_valid_i` is ignored in IDLE and HOLD.
- Exactly one request is outstanding at any time.
- `pc_plus_4_o = pc_q + 4`, modulo 2^ADDR_LEN; 0xFFFF_FFFC wraps to 0x0000_0000.
- `inst_pc_o = pc_q`. `inst_o = inst_q`.
- `pc_we_o` is combinational and only ever high in HOLD during a handshake.

## Timing
- Reset values:
  - state = IDLE, `pc_q = RESET_PC`, `inst_q = 0`, `discard_q = 0`.
  - `imem_req_valid_o` returns high on the first cycle after reset unless a flush is present.
  - `inst_valid_o = 0`, `pc_we_o = 0`.
- Reset mid-WAIT or mid-HOLD:
  - Returns to IDLE on the next edge; the pending instruction is lost.
  - A late response arriving in IDLE is ignored.
- Memory responds no earlier than the cycle after request acceptance.
- Latency with a zero-wait memory:
  - request accepted in cycle N, response in N+1, `inst_valid_o` in N+2.
  - Earliest `pc_we_o` is N+2; the next request is in N+3.
- Handshake stability: once asserted, `imem_req_valid_o`/`imem_addr_o` and `inst_valid_o`/`inst_o` stay stable until accepted, except when a flush occurs.
- Simultaneous events:
  - Flush and `rsp_valid` in the same cycle: the flush wins and the data is dropped.
  - Flush and `inst_ready_i` in HOLD: the flush wins and there is no `pc_we_o`.

## Structure
- Shared package `ysyx_22041211_pkg` holds:
  - the FSM state typedef (IDLE/WAIT/HOLD, 2-bit);
  - `RESET_PC` default;
  - `INST_NOP` = 32'h0000_0013, used by benches.
- No sub-module is required.
- `pc_q` and `inst_q` use the existing `ysyx_22041211_Reg` with write enables.

## Test plan
- Reset then zero-wait memory, `pc_i` = 0x8000_0000, `rsp_data` = 0x0000_0013:
  - `inst_valid_o` high 2 cycles after accept, with `inst_o` = 0x13.
  - `inst_pc_o` = 0x8000_0000, `pc_plus_4_o` = 0x8000_0004.
  - `pc_we_o` pulses once with `inst_ready_i`.
- `imem_req_ready_i` low for 3 cycles: `imem_req_valid_o` and `imem_addr_o` are held constant, and the state stays IDLE.
- `inst_ready_i` low for 5 cycles in HOLD:
  - `inst_o` is stable, no new request is issued, and `pc_we_o` stays 0.
  - Acceptance on cycle 6 gives a single `pc_we_o`.
- Flush in WAIT two cycles before the response:
  - The response is dropped and `inst_valid_o` never rises.
  - The next request addresses the new `pc_i` = 0x8000_0100.
- Flush coincident with the response, and separately flush in HOLD with `inst_ready_i` = 1: the instruction is discarded, `pc_we_o` = 0, and the state returns to IDLE.
- Reset asserted in WAIT:
  - Next cycle `inst_valid_o` = 0 and `pc_q` = 0x8000_0000.
  - A stale `rsp_valid` one cycle later produces no `inst_valid_o`.

Source files
------------

// File: rtl/ysyx_22041211_pkg.sv
// Shared types and constants for the NPC fetch path.
package ysyx_22041211_pkg;

  // Fetch FSM: issue request, wait for memory, hold instruction for decode.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/ysyx_22041211_Reg.sv
// Generic register with synchronous active-high reset and write enable.
module ysyx_22041211_Reg #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  // Load on write enable; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: single-outstanding imem request, holds the fetched
// instruction for decode and strobes the PC counter when decode accepts it.
module ysyx_22041211_ifu
  import ysyx_22041211_pkg::*;
#(
  parameter int unsigned         ADDR_LEN = 32,
  parameter int unsigned         DATA_LEN = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic                branch_flush_i,
  output logic                imem_req_valid_o,
  input  logic                imem_req_ready_i,
  output logic [ADDR_LEN-1:0] imem_addr_o,
  input  logic                imem_rsp_valid_i,
  input  logic [DATA_LEN-1:0] imem_rsp_data_i,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  output logic [DATA_LEN-1:0] inst_o,
  output logic [ADDR_LEN-1:0] inst_pc_o,
  output logic [ADDR_LEN-1:0] pc_plus_4_o,
  output logic                pc_we_o
);

  ifu_state_e          state_q, state_d;
  logic                discard_q, discard_d;
  logic                pc_wen, inst_wen;
  logic [ADDR_LEN-1:0] pc_q;
  logic [DATA_LEN-1:0] inst_q;

  ysyx_22041211_Reg #(
    .WIDTH     (ADDR_LEN),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .din  (pc_i),
    .dout (pc_q),
    .wen  (pc_wen)
  );

  ysyx_22041211_Reg #(
    .WIDTH     (DATA_LEN),
    .RESET_VAL ('0)
  ) u_inst_reg (
    .clk  (clk),
    .rst  (rst),
    .din  (imem_rsp_data_i),
    .dout (inst_q),
    .wen  (inst_wen)
  );

  // FSM state and the "drop the in-flight response" flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  // Next-state, handshake and register-enable decode.
  always_comb begin
    state_d          = state_q;
    discard_d        = discard_q;
    imem_req_valid_o = 1'b0;
    inst_valid_o     = 1'b0;
    pc_we_o          = 1'b0;
    pc_wen           = 1'b0;
    inst_wen         = 1'b0;
    unique case (state_q)
      StIdle: begin
        imem_req_valid_o = ~branch_flush_i;
        if (imem_req_valid_o && imem_req_ready_i) begin
          pc_wen  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_rsp_valid_i) begin
          if (discard_q || branch_flush_i) begin
            discard_d = 1'b0;
            state_d   = StIdle;
          end else begin
            inst_wen = 1'b1;
            state_d  = StHold;
          end
        end else if (branch_flush_i) begin
          // Response still owed by memory; swallow it when it arrives.
          discard_d = 1'b1;
        end
      end
      StHold: begin
        inst_valid_o = ~branch_flush_i;
        if (branch_flush_i) begin
          state_d = StIdle;
        end else if (inst_ready_i) begin
          pc_we_o = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign imem_addr_o = pc_i;
  assign inst_o      = inst_q;
  assign inst_pc_o   = pc_q;
  assign pc_plus_4_o = pc_q + ADDR_LEN'(4);

endmodule
